// File: rtl/mcu_run_step_ctrl.sv
// Run/step/breakpoint sequencer issuing one-clock datapath advance pulses.
// Optional breakpoint compare and BRKHIT state: define MCU_RUN_STEP_BRK_EN.
module mcu_run_step_ctrl #(
  parameter int PC_W    = 16,
  parameter int CNT_W   = 32,
  parameter int DIV_W   = 24,
  parameter int RUN_DIV = 5000000
) (
  input  logic             clk_in,
  input  logic             Clear,
  input  logic             run,
  input  logic             step,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  brk_addr,
  input  logic             brk_arm,
  output logic             adv,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycles,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_HALT   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_BRKHIT = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  state_t             r_state, w_state_nxt;
  logic               r_adv, w_adv_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [CNT_W-1:0]   r_cycles;
  logic               r_halted;
  logic               w_brk;

`ifdef MCU_RUN_STEP_BRK_EN
  // pc lags adv by one edge, so skip the compare while adv is high
  assign w_brk = brk_arm && (pc == brk_addr) && !r_adv;
`else
  logic w_unused;
  assign w_unused = ^{pc, brk_addr, brk_arm};
  assign w_brk    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_adv_nxt   = 1'b0;
    w_div_nxt   = r_div;
    case (r_state)
      S_HALT: begin
        if (run) begin
          w_state_nxt = S_RUN;
          w_div_nxt   = '0;
        end else if (step) begin
          w_state_nxt = S_STEP;
          w_adv_nxt   = 1'b1;
        end
      end
      S_STEP: w_state_nxt = S_HALT;
      S_RUN: begin
        if (!run) begin
          w_state_nxt = S_HALT;
          w_div_nxt   = '0;
        end else if (w_brk) begin
          w_state_nxt = S_BRKHIT;
        end else if (r_div == DIV_LAST) begin
          w_adv_nxt = 1'b1;
          w_div_nxt = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_BRKHIT: begin
        // step wins so a held run resumes through STEP -> HALT -> RUN
        if (step) begin
          w_state_nxt = S_STEP;
          w_adv_nxt   = 1'b1;
        end else if (!run) begin
          w_state_nxt = S_HALT;
        end
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk_in or posedge Clear) begin
    if (Clear) begin
      r_state  <= S_HALT;
      r_adv    <= 1'b0;
      r_div    <= '0;
      r_cycles <= '0;
      r_halted <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_adv    <= w_adv_nxt;
      r_div    <= w_div_nxt;
      r_cycles <= r_cycles + {{(CNT_W-1){1'b0}}, r_adv};
      r_halted <= (w_state_nxt != S_RUN);
    end
  end

  assign adv    = r_adv;
  assign state  = r_state;
  assign cycles = r_cycles;
  assign halted = r_halted;

endmodule
